// File: rtl/pe_row_db.sv
// Weight-stationary PE row with two weight banks per PE; each activation carries
// the bank tag it multiplies against, so reloads overlap with compute on the other bank.

module pe_row_db_pe #(
  parameter int DW  = 32,
  parameter int AW  = 64,
  parameter int SAT = 1
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_en,
  input  logic          i_w_en,
  input  logic          i_w_bank,
  input  logic [DW-1:0] i_w,
  input  logic          i_v,
  input  logic          i_b,
  input  logic [DW-1:0] i_a,
  input  logic [AW-1:0] i_sum,
  input  logic          i_clr_ovf,
  output logic          o_v,
  output logic          o_b,
  output logic [DW-1:0] o_a,
  output logic [DW-1:0] o_w,
  output logic [AW-1:0] o_sum,
  output logic          o_sum_vld,
  output logic          o_ovf
);
  logic                   r_v, r_b, r_ovf, r_sum_vld;
  logic [DW-1:0]          r_a, r_w0, r_w1, r_wout;
  logic [AW-1:0]          r_sum;
  logic signed [2*DW-1:0] w_ae, w_we, w_p;
  logic signed [AW-1:0]   w_pext, w_s, w_res;
  logic                   w_ovf;

  // Bank is read before any same-edge write lands, so a colliding MAC sees the old weight.
  assign w_ae   = $signed(i_a);
  assign w_we   = $signed(i_b ? r_w1 : r_w0);
  assign w_p    = w_ae * w_we;
  assign w_pext = w_p;
  assign w_s    = $signed(i_sum) + w_pext;
  assign w_ovf  = (i_sum[AW-1] == w_pext[AW-1]) && (w_s[AW-1] != i_sum[AW-1]);

  always_comb begin
    w_res = w_s;
    if ((SAT != 0) && w_ovf)
      w_res = i_sum[AW-1] ? {1'b1, {(AW-1){1'b0}}} : {1'b0, {(AW-1){1'b1}}};
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_v       <= 1'b0;
      r_b       <= 1'b0;
      r_a       <= '0;
      r_w0      <= '0;
      r_w1      <= '0;
      r_wout    <= '0;
      r_sum     <= '0;
      r_sum_vld <= 1'b0;
      r_ovf     <= 1'b0;
    end else if (i_en) begin
      r_v <= i_v;
      r_b <= i_b;
      r_a <= i_a;
      if (i_w_en) begin
        if (i_w_bank) r_w1 <= i_w;
        else          r_w0 <= i_w;
        r_wout <= i_w;
      end
      r_sum     <= i_v ? w_res : i_sum;
      r_sum_vld <= i_v;
      r_ovf     <= (r_ovf & ~i_clr_ovf) | (i_v & w_ovf);
    end
  end

  assign o_v       = r_v;
  assign o_b       = r_b;
  assign o_a       = r_a;
  assign o_w       = r_wout;
  assign o_sum     = r_sum;
  assign o_sum_vld = r_sum_vld;
  assign o_ovf     = r_ovf;
endmodule

// AW must be at least 2*DW so the full product fits before accumulation.
module pe_row_db #(
  parameter int NUM = 16,
  parameter int DW  = 32,
  parameter int AW  = 64,
  parameter int SAT = 1
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              EN,
  input  logic              W_EN,
  input  logic              W_BANK,
  input  logic [NUM*DW-1:0] in_weight_above,
  output logic [NUM*DW-1:0] out_weight_below,
  input  logic              act_valid_left,
  input  logic              act_bank_left,
  input  logic [DW-1:0]     active_left,
  output logic              act_valid_right,
  output logic              act_bank_right,
  output logic [DW-1:0]     active_right,
  input  logic [NUM*AW-1:0] in_sum,
  output logic [NUM*AW-1:0] out_sum,
  output logic [NUM-1:0]    out_sum_valid,
  input  logic              CLR_OVF,
  output logic [NUM-1:0]    ovf
);
  logic [NUM:0]         w_v, w_b;
  logic [NUM:0][DW-1:0] w_a;

  assign w_v[0] = act_valid_left;
  assign w_b[0] = act_bank_left;
  assign w_a[0] = active_left;

  for (genvar i = 0; i < NUM; i++) begin : g_pe
    pe_row_db_pe #(.DW(DW), .AW(AW), .SAT(SAT)) u_pe (
      .i_clk     (CLK),
      .i_rst     (RESET),
      .i_en      (EN),
      .i_w_en    (W_EN),
      .i_w_bank  (W_BANK),
      .i_w       (in_weight_above[i*DW +: DW]),
      .i_v       (w_v[i]),
      .i_b       (w_b[i]),
      .i_a       (w_a[i]),
      .i_sum     (in_sum[i*AW +: AW]),
      .i_clr_ovf (CLR_OVF),
      .o_v       (w_v[i+1]),
      .o_b       (w_b[i+1]),
      .o_a       (w_a[i+1]),
      .o_w       (out_weight_below[i*DW +: DW]),
      .o_sum     (out_sum[i*AW +: AW]),
      .o_sum_vld (out_sum_valid[i]),
      .o_ovf     (ovf[i])
    );
  end

  assign act_valid_right = w_v[NUM];
  assign act_bank_right  = w_b[NUM];
  assign active_right    = w_a[NUM];
endmodule

// File: tb/tb_pe_row_db.sv
// Randomized bench for pe_row_db: one saturating and one wrapping instance share
// stimulus and are checked against a history-indexed reference model.
module tb_pe_row_db;
  localparam int NUM = 4, DW = 8, AW = 16, HN = 4096;

  logic clk = 0, RESET = 1, EN = 0, W_EN = 0, W_BANK = 0, CLR_OVF = 0;
  logic [NUM*DW-1:0] in_weight_above = '0;
  logic act_valid_left = 0, act_bank_left = 0;
  logic [DW-1:0] active_left = '0;
  logic [NUM*AW-1:0] in_sum = '0;

  logic [NUM*DW-1:0] owb_s, owb_w;
  logic vr_s, vr_w, br_s, br_w;
  logic [DW-1:0] ar_s, ar_w;
  logic [NUM*AW-1:0] os_s, os_w;
  logic [NUM-1:0] osv_s, osv_w, ovf_s, ovf_w;

  always #5 clk = ~clk;

  pe_row_db #(.NUM(NUM), .DW(DW), .AW(AW), .SAT(1)) u_sat (
    .CLK(clk), .RESET(RESET), .EN(EN), .W_EN(W_EN), .W_BANK(W_BANK),
    .in_weight_above(in_weight_above), .out_weight_below(owb_s),
    .act_valid_left(act_valid_left), .act_bank_left(act_bank_left), .active_left(active_left),
    .act_valid_right(vr_s), .act_bank_right(br_s), .active_right(ar_s),
    .in_sum(in_sum), .out_sum(os_s), .out_sum_valid(osv_s), .CLR_OVF(CLR_OVF), .ovf(ovf_s));

  pe_row_db #(.NUM(NUM), .DW(DW), .AW(AW), .SAT(0)) u_wrap (
    .CLK(clk), .RESET(RESET), .EN(EN), .W_EN(W_EN), .W_BANK(W_BANK),
    .in_weight_above(in_weight_above), .out_weight_below(owb_w),
    .act_valid_left(act_valid_left), .act_bank_left(act_bank_left), .active_left(active_left),
    .act_valid_right(vr_w), .act_bank_right(br_w), .active_right(ar_w),
    .in_sum(in_sum), .out_sum(os_w), .out_sum_valid(osv_w), .CLR_OVF(CLR_OVF), .ovf(ovf_w));

  int n_chk = 0, n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
    end
  endtask

  // Model: activation entered at enabled step j reaches column i at step j+i.
  int ec = 0, rmark = 0;
  logic hv[HN], hb[HN];
  int   ha[HN];
  int   mw[2][NUM];
  int   mwout[NUM];
  longint ms_s[NUM], ms_w[NUM];
  bit   mvld[NUM], movf_s[NUM], movf_w[NUM];
  bit   mrv, mrb;
  int   mra;

  task automatic model_reset();
    rmark = ec;
    mrv = 0; mrb = 0; mra = 0;
    for (int i = 0; i < NUM; i++) begin
      mw[0][i] = 0; mw[1][i] = 0; mwout[i] = 0;
      ms_s[i] = 0; ms_w[i] = 0; mvld[i] = 0; movf_s[i] = 0; movf_w[i] = 0;
    end
  endtask

  task automatic model_step();
    longint mx, mn, s, ins;
    logic [AW-1:0] t;
    int j, a;
    bit v, b, o;
    if (!EN) return;
    mx = (longint'(1) <<< (AW-1)) - 1;
    mn = -(longint'(1) <<< (AW-1));
    hv[ec] = act_valid_left; hb[ec] = act_bank_left; ha[ec] = $signed(active_left);
    for (int i = 0; i < NUM; i++) begin
      j = ec - i;
      v = (j >= rmark) ? hv[j] : 1'b0;
      b = (j >= rmark) ? hb[j] : 1'b0;
      a = (j >= rmark) ? ha[j] : 0;
      ins = $signed(in_sum[i*AW +: AW]);
      if (CLR_OVF) begin movf_s[i] = 0; movf_w[i] = 0; end
      if (v) begin
        s = ins + longint'(a) * longint'(mw[b][i]);
        o = (s > mx) || (s < mn);
        t = s[AW-1:0];
        ms_w[i] = $signed(t);
        ms_s[i] = (s > mx) ? mx : (s < mn) ? mn : s;
        if (o) begin movf_s[i] = 1; movf_w[i] = 1; end
      end else begin
        ms_s[i] = ins; ms_w[i] = ins;
      end
      mvld[i] = v;
    end
    j = ec - (NUM-1);
    mrv = (j >= rmark) ? hv[j] : 1'b0;
    mrb = (j >= rmark) ? hb[j] : 1'b0;
    mra = (j >= rmark) ? ha[j] : 0;
    if (W_EN)
      for (int i = 0; i < NUM; i++) begin
        mw[W_BANK][i] = $signed(in_weight_above[i*DW +: DW]);
        mwout[i] = $signed(in_weight_above[i*DW +: DW]);
      end
    ec++;
  endtask

  task automatic compare();
    logic [NUM*AW-1:0] es_s, es_w;
    logic [NUM*DW-1:0] ewb;
    logic [NUM-1:0] ev, eos, eow;
    logic [DW-1:0] era;
    for (int i = 0; i < NUM; i++) begin
      es_s[i*AW +: AW] = ms_s[i][AW-1:0];
      es_w[i*AW +: AW] = ms_w[i][AW-1:0];
      ewb[i*DW +: DW]  = mwout[i][DW-1:0];
      ev[i] = mvld[i]; eos[i] = movf_s[i]; eow[i] = movf_w[i];
    end
    era = mra[DW-1:0];
    chk("sum_sat",  os_s, es_s);
    chk("sum_wrap", os_w, es_w);
    chk("sum_vld",  {osv_s, osv_w}, {ev, ev});
    chk("ovf_sat",  ovf_s, eos);
    chk("ovf_wrap", ovf_w, eow);
    chk("wbelow",   {owb_s, owb_w}, {ewb, ewb});
    chk("act_right", {vr_s, br_s, ar_s, vr_w, br_w, ar_w}, {mrv, mrb, era, mrv, mrb, era});
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    compare();
  endtask

  task automatic set_w(input int w0, input int w1, input int w2, input int w3);
    in_weight_above = {w3[DW-1:0], w2[DW-1:0], w1[DW-1:0], w0[DW-1:0]};
  endtask

  task automatic act(input bit v, input bit b, input int a);
    act_valid_left = v; act_bank_left = b; active_left = a[DW-1:0];
  endtask

  task automatic mid_reset();
    #2 RESET = 1;
    #1;
    chk("rst_zero", {os_s, osv_s, ovf_s, owb_s, vr_s, ar_s}, '0);
    model_reset();
    compare();
    #1 RESET = 0;
  endtask

  initial begin
    model_reset();
    #1;
    chk("por_zero", {os_s, osv_s, ovf_s, owb_s, vr_s, br_s, ar_s}, '0);
    #12 RESET = 0; EN = 1;

    // Load bank0 = {1,2,3,4} and stream a=5 down the row.
    W_EN = 1; W_BANK = 0; set_w(1, 2, 3, 4);
    cyc();
    chk("wbelow_load", owb_s, 32'h04030201);
    W_EN = 0; act(1, 0, 5);
    cyc();
    chk("col0_5", os_s[0 +: AW], 16'd5);
    act(0, 0, 0);
    cyc(); chk("col1_10", os_s[AW +: AW], 16'd10);
    cyc(); chk("col2_15", os_s[2*AW +: AW], 16'd15);
    cyc(); chk("col3_20", {vr_s, ar_s, os_s[3*AW +: AW]}, {1'b1, 8'd5, 16'd20});
    cyc();

    // Bank 1 = -1, then back-to-back tagged activations.
    W_EN = 1; W_BANK = 1; set_w(-1, -1, -1, -1);
    cyc();
    W_EN = 0; act(1, 0, 2); cyc();
    chk("tag_b0", os_s[0 +: AW], 16'd2);
    act(1, 1, 3); cyc();
    chk("tag_b1", {os_s[0 +: AW], os_s[AW +: AW]}, {16'hFFFD, 16'd4});
    act(0, 0, 0);
    repeat (4) cyc();

    // Collision: write bank0 col0=7 on the edge a b=0 activation hits PE0.
    W_EN = 1; W_BANK = 0; set_w(7, 2, 3, 4); act(1, 0, 1);
    cyc(); chk("coll_old", os_s[0 +: AW], 16'd1);
    W_EN = 0; cyc(); chk("coll_new", os_s[0 +: AW], 16'd7);
    act(0, 0, 0); repeat (4) cyc();

    // Saturation vs wrap on column 0.
    W_EN = 1; W_BANK = 0; set_w(127, 1, 1, 1); cyc();
    W_EN = 0; in_sum = '0; in_sum[0 +: AW] = 16'd30000; act(1, 0, 127);
    cyc();
    chk("sat_val", os_s[0 +: AW], 16'h7FFF);
    chk("wrap_val", os_w[0 +: AW], 16'hB431);
    chk("ovf_set", {ovf_s[0], ovf_w[0]}, 2'b11);
    act(0, 0, 0); in_sum = '0; CLR_OVF = 1;
    cyc(); chk("ovf_clr", {ovf_s[0], ovf_w[0]}, 2'b00);
    CLR_OVF = 0; repeat (3) cyc();

    // Stall mid-stream with junk on the control inputs.
    act(1, 0, 9); cyc();
    EN = 0; W_EN = 1; CLR_OVF = 1; act(1, 1, 33); set_w(9, 9, 9, 9);
    repeat (3) cyc();
    EN = 1; W_EN = 0; CLR_OVF = 0; act(0, 0, 0);
    repeat (5) cyc();

    // Reset while activations are in flight.
    act(1, 0, 3); cyc(); cyc(); act(0, 0, 0);
    mid_reset();
    repeat (NUM + 1) cyc();

    // Randomized traffic.
    for (int k = 0; k < 400; k++) begin
      EN      = ($urandom_range(0, 9) != 0);
      W_EN    = ($urandom_range(0, 3) == 0);
      W_BANK  = $urandom_range(0, 1);
      CLR_OVF = ($urandom_range(0, 15) == 0);
      in_weight_above = $urandom;
      act($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 255));
      for (int i = 0; i < NUM; i++) in_sum[i*AW +: AW] = $urandom_range(0, 65535);
      cyc();
      if (k == 200) mid_reset();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end
endmodule
